// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order instruction-memory requests with bounded
// credit, buffers returned words in a small FIFO and presents them to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_FET_pause,
  input  logic        i_FET_redirect,
  input  logic [31:0] i_FET_redirectPC,
  output logic        o_FET_iMemReq,
  output logic [31:0] o_FET_iMemAddr,
  input  logic        i_FET_iMemGnt,
  input  logic        i_FET_iMemRValid,
  input  logic [31:0] i_FET_iMemRData,
  output logic        o_FET_valid,
  output logic [31:0] o_FET_PC,
  output logic [31:0] o_FET_inst,
  output logic [25:0] o_FET_lowPC
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] tag_wr, tag_rd;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] tag_q     [DEPTH];

  logic        req_int;
  logic        grant;
  logic        rsp;
  logic        keep;
  logic        pop;
  logic [CW:0] used;
  logic        redirect_lsb_unused;

  assign redirect_lsb_unused = ^i_FET_redirectPC[1:0];

  assign o_FET_valid = (fifo_cnt != '0) & ~i_FET_redirect;
  assign pop         = o_FET_valid & ~i_FET_pause;

  // Credit counts buffered words plus in-flight words (stale ones included), so
  // every outstanding response always has a FIFO slot waiting for it.
  assign used    = {1'b0, fifo_cnt} + {1'b0, out_cnt} - (CW+1)'(pop);
  assign req_int = ~i_FET_redirect & (used < (CW+1)'(DEPTH));
  assign grant   = req_int & i_FET_iMemGnt;
  assign rsp     = i_FET_iMemRValid;
  assign keep    = rsp & (drop_cnt == '0) & ~i_FET_redirect;

  assign o_FET_iMemReq  = req_int & rstn;
  assign o_FET_iMemAddr = fetch_pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(grant) - CW'(rsp);
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wr   <= tag_wr + AW'(1);
      end
      if (rsp) tag_rd <= tag_rd + AW'(1);
      if (i_FET_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= {i_FET_redirectPC[31:2], 2'b00};
        drop_cnt <= out_cnt - CW'(rsp);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (keep) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(keep) - CW'(pop);
      end
    end
  end

  // Tag and FIFO payload storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (grant) tag_q[tag_wr] <= fetch_pc;
    if (keep) begin
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
      fifo_inst[wr_ptr] <= i_FET_iMemRData;
    end
  end

  assign o_FET_PC    = o_FET_valid ? (fifo_pc[rd_ptr] + 32'd4) : 32'd0;
  assign o_FET_inst  = o_FET_valid ? fifo_inst[rd_ptr] : 32'd0;
  assign o_FET_lowPC = o_FET_inst[25:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for latency,
// redirect and async reset, then randomized traffic against a queue-based model.
module tb_fetch_stage;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_FET_pause = 1'b0;
  logic        i_FET_redirect = 1'b0;
  logic [31:0] i_FET_redirectPC = 32'd0;
  logic        o_FET_iMemReq;
  logic [31:0] o_FET_iMemAddr;
  logic        i_FET_iMemGnt = 1'b0;
  logic        i_FET_iMemRValid = 1'b0;
  logic [31:0] i_FET_iMemRData = 32'd0;
  logic        o_FET_valid;
  logic [31:0] o_FET_PC;
  logic [31:0] o_FET_inst;
  logic [25:0] o_FET_lowPC;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .i_FET_pause(i_FET_pause), .i_FET_redirect(i_FET_redirect),
    .i_FET_redirectPC(i_FET_redirectPC),
    .o_FET_iMemReq(o_FET_iMemReq), .o_FET_iMemAddr(o_FET_iMemAddr),
    .i_FET_iMemGnt(i_FET_iMemGnt), .i_FET_iMemRValid(i_FET_iMemRValid),
    .i_FET_iMemRData(i_FET_iMemRData),
    .o_FET_valid(o_FET_valid), .o_FET_PC(o_FET_PC),
    .o_FET_inst(o_FET_inst), .o_FET_lowPC(o_FET_lowPC)
  );

  always #5 clk = ~clk;

  // Memory: in-order responses, each with its own due cycle.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rsp_q[$];
  int   last_due, lat_min, lat_max;
  logic [31:0] mem_xor;

  // Reference model: in-flight fetches (with stale flag) and buffered entries.
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  fl_t  m_fl[$];
  ent_t m_fifo[$];
  logic [31:0] m_pc;

  int cyc, n_chk, n_pass;
  bit s_mv, s_mpop, s_mreq, s_rv, s_rd, s_g;
  logic [31:0] s_ra, s_rpc;

  typedef struct {
    bit pz; bit rd; logic [31:0] rpc;
    bit vld; logic [31:0] pc; logic [31:0] inst; bit req; logic [31:0] addr;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic clear_models();
    rsp_q.delete(); m_fl.delete(); m_fifo.delete();
    m_pc = RESET_PC; last_due = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_FET_pause = 0; i_FET_redirect = 0; i_FET_iMemGnt = 0; i_FET_iMemRValid = 0;
    #1;
    chk("rst_req",   {31'd0, o_FET_iMemReq}, 32'd0);
    chk("rst_valid", {31'd0, o_FET_valid},   32'd0);
    chk("rst_pc",    o_FET_PC,               32'd0);
    chk("rst_inst",  o_FET_inst,             32'd0);
    chk("rst_low",   {6'd0, o_FET_lowPC},    32'd0);
    clear_models();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cyc = 0;
  endtask

  // Drive one cycle's inputs, sample at the falling edge and compare with the model.
  task automatic step_a(input bit pz, input bit rd, input logic [31:0] rpc, input bit g);
    int used;
    s_rd = rd; s_rpc = rpc; s_g = g;
    i_FET_pause = pz; i_FET_redirect = rd; i_FET_redirectPC = rpc; i_FET_iMemGnt = g;
    s_rv = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    s_ra = s_rv ? (rsp_q[0].addr ^ mem_xor) : $urandom();
    i_FET_iMemRValid = s_rv; i_FET_iMemRData = s_ra;
    @(negedge clk);
    s_mv   = (m_fifo.size() != 0) && !rd;
    s_mpop = s_mv && !pz;
    used   = m_fifo.size() + m_fl.size() - int'(s_mpop);
    s_mreq = (used < DEPTH) && !rd;
    chk("req",   {31'd0, o_FET_iMemReq}, {31'd0, s_mreq});
    if (s_mreq) chk("addr", o_FET_iMemAddr, m_pc);
    chk("valid", {31'd0, o_FET_valid}, {31'd0, s_mv});
    chk("pc",    o_FET_PC,   s_mv ? m_fifo[0].pc + 32'd4 : 32'd0);
    chk("inst",  o_FET_inst, s_mv ? m_fifo[0].inst : 32'd0);
    chk("lowpc", {6'd0, o_FET_lowPC}, s_mv ? {6'd0, m_fifo[0].inst[25:0]} : 32'd0);
  endtask

  task automatic step_b();
    fl_t  f;
    ent_t e;
    int   lat, due;
    if (s_mpop) void'(m_fifo.pop_front());
    if (s_rv && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (!f.stale && !s_rd) begin
        e.pc = f.pc; e.inst = s_ra;
        m_fifo.push_back(e);
      end
    end
    if (s_rd) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc = {s_rpc[31:2], 2'b00};
    end
    if (s_mreq && s_g) begin
      f.pc = m_pc; f.stale = 1'b0;
      m_fl.push_back(f);
      m_pc = m_pc + 32'd4;
    end
    if (s_rv) void'(rsp_q.pop_front());
    if (o_FET_iMemReq && s_g) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      rsp_q.push_back('{addr: o_FET_iMemAddr, due: due});
      last_due = due;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic step(input bit pz, input bit rd, input logic [31:0] rpc, input bit g);
    step_a(pz, rd, rpc, g);
    step_b();
  endtask

  initial begin
    int cnt;
    bit found;
    n_chk = 0; n_pass = 0; cyc = 0;
    lat_min = 1; lat_max = 1; mem_xor = 32'd0;

    // Zero-wait stream, pause for two cycles, then redirect coincident with rvalid and pause.
    tbl[0]  = '{0, 0, 32'h0,   0, 32'h0,   32'h0,   1, 32'h0};
    tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,   32'h0,   1, 32'h4};
    tbl[2]  = '{0, 0, 32'h0,   1, 32'h4,   32'h0,   1, 32'h8};
    tbl[3]  = '{0, 0, 32'h0,   1, 32'h8,   32'h4,   1, 32'hC};
    tbl[4]  = '{1, 0, 32'h0,   1, 32'hC,   32'h8,   0, 32'h0};
    tbl[5]  = '{1, 0, 32'h0,   1, 32'hC,   32'h8,   0, 32'h0};
    tbl[6]  = '{0, 0, 32'h0,   1, 32'hC,   32'h8,   1, 32'h10};
    tbl[7]  = '{0, 0, 32'h0,   1, 32'h10,  32'hC,   1, 32'h14};
    tbl[8]  = '{1, 1, 32'h103, 0, 32'h0,   32'h0,   0, 32'h0};
    tbl[9]  = '{0, 0, 32'h0,   0, 32'h0,   32'h0,   1, 32'h100};
    tbl[10] = '{0, 0, 32'h0,   0, 32'h0,   32'h0,   1, 32'h104};
    tbl[11] = '{0, 0, 32'h0,   1, 32'h104, 32'h100, 1, 32'h108};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step_a(tbl[i].pz, tbl[i].rd, tbl[i].rpc, 1'b1);
      chk($sformatf("t%0d_valid", i), {31'd0, o_FET_valid}, {31'd0, tbl[i].vld});
      chk($sformatf("t%0d_pc", i),    o_FET_PC,   tbl[i].pc);
      chk($sformatf("t%0d_inst", i),  o_FET_inst, tbl[i].inst);
      chk($sformatf("t%0d_req", i),   {31'd0, o_FET_iMemReq}, {31'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), o_FET_iMemAddr, tbl[i].addr);
      step_b();
    end

    // Latency-3 memory: DEPTH words per four cycles once settled.
    lat_min = 3; lat_max = 3;
    repeat (8) step(0, 0, 32'h0, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_a(0, 0, 32'h0, 1);
      if (o_FET_valid) cnt++;
      step_b();
    end
    chk("lat3_throughput", cnt, 32'd8);

    // Redirect with two requests in flight: both stale words must be dropped.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_fl.size() == 2 && m_fifo.size() == 0) found = 1;
      else step(0, 0, 32'h0, 1);
    end
    chk("two_inflight_found", {31'd0, found}, 32'd1);
    step_a(0, 1, 32'h0000_0100, 1);
    chk("redir_valid", {31'd0, o_FET_valid}, 32'd0);
    step_b();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_a(0, 0, 32'h0, 1);
      if (o_FET_valid) begin
        found = 1;
        chk("redir_first_pc",   o_FET_PC,   32'h104);
        chk("redir_first_inst", o_FET_inst, 32'h100);
      end
      step_b();
    end
    chk("redir_valid_seen", {31'd0, found}, 32'd1);

    // Asynchronous reset in the middle of a stream.
    lat_min = 1; lat_max = 1;
    repeat (5) step(0, 0, 32'h0, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_req",   {31'd0, o_FET_iMemReq}, 32'd0);
    chk("async_valid", {31'd0, o_FET_valid},   32'd0);
    chk("async_pc",    o_FET_PC,               32'd0);
    chk("async_inst",  o_FET_inst,             32'd0);
    do_reset();
    step_a(0, 0, 32'h0, 1);
    chk("restart_addr", o_FET_iMemAddr, RESET_PC);
    step_b();
    step(0, 0, 32'h0, 1);
    step_a(0, 0, 32'h0, 1);
    chk("restart_pc", o_FET_PC, RESET_PC + 32'd4);
    step_b();

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 4; mem_xor = 32'hA5C3_0F00;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3, 0) == 0),
           ($urandom_range(24, 0) == 0),
           $urandom(),
           ($urandom_range(3, 0) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
